// File: rtl/binary_to_bcd_if.sv
// Handshake and result bus between a conversion requester and binary_to_bcd.
interface binary_to_bcd_if #(
  parameter int unsigned BIN_WIDTH = 16,
  parameter int unsigned DIGITS    = 5
);
  logic                   start;
  logic [BIN_WIDTH-1:0]   binary;
  logic                   ready;
  logic                   valid;
  logic [4*DIGITS-1:0]    bcd;
  logic                   overflow;

  modport master (
    output start,
    output binary,
    input  ready,
    input  valid,
    input  bcd,
    input  overflow
  );

  modport slave (
    input  start,
    input  binary,
    output ready,
    output valid,
    output bcd,
    output overflow
  );
endinterface

// File: rtl/binary_to_bcd.sv
// Sequential double-dabble converter: one binary bit per clock into packed BCD
// digits, with a start/ready/valid handshake and a sticky overflow flag.
module binary_to_bcd #(
  parameter int unsigned BIN_WIDTH = 16,
  parameter int unsigned DIGITS    = 5
) (
  input  logic            clock,
  input  logic            reset,
  binary_to_bcd_if.slave  bus
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned CNT_W = $clog2(BIN_WIDTH + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [BIN_WIDTH-1:0] shift_q, shift_d;
  logic [BCD_W-1:0]     scratch_q, scratch_d;
  logic                 ovf_scr_q, ovf_scr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BCD_W-1:0]     bcd_q, bcd_d;
  logic                 ovf_q, ovf_d;
  logic                 valid_q, valid_d;
  logic                 ready_q, ready_d;

  logic [BCD_W-1:0]     adj_c;
  logic [BCD_W-1:0]     shifted_c;
  logic                 carry_c;
  logic                 last_c;

  // Final iteration of a conversion is in flight this cycle.
  assign last_c = (state_q == SHIFT) && (cnt_q == CNT_W'(1));

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: accept start only when idle, return after the last bit.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = SHIFT;
      SHIFT:   if (last_c)    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Add-3 correction on every scratch digit, then one-bit left shift of
  // {scratch, shift}; the bit leaving the top digit marks >= 10^DIGITS.
  always_comb begin
    adj_c = scratch_q;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (scratch_q[4*k +: 4] >= 4'd5) begin
        adj_c[4*k +: 4] = scratch_q[4*k +: 4] + 4'd3;
      end
    end
    carry_c   = adj_c[BCD_W-1];
    shifted_c = (adj_c << 1) | BCD_W'(shift_q[BIN_WIDTH-1]);
  end

  // Output/datapath next values; results only move on the completing edge.
  always_comb begin
    shift_d   = shift_q;
    scratch_d = scratch_q;
    ovf_scr_d = ovf_scr_q;
    cnt_d     = cnt_q;
    bcd_d     = bcd_q;
    ovf_d     = ovf_q;
    valid_d   = 1'b0;
    ready_d   = ready_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          shift_d   = bus.binary;
          scratch_d = '0;
          ovf_scr_d = 1'b0;
          cnt_d     = CNT_W'(BIN_WIDTH);
          ready_d   = 1'b0;
        end
      end
      SHIFT: begin
        shift_d   = shift_q << 1;
        scratch_d = shifted_c;
        ovf_scr_d = ovf_scr_q | carry_c;
        cnt_d     = cnt_q - CNT_W'(1);
        if (last_c) begin
          bcd_d   = shifted_c;
          ovf_d   = ovf_scr_q | carry_c;
          valid_d = 1'b1;
          ready_d = 1'b1;
        end
      end
      default: begin
        ready_d = 1'b1;
      end
    endcase
  end

  // Datapath and registered handshake outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      shift_q   <= '0;
      scratch_q <= '0;
      ovf_scr_q <= 1'b0;
      cnt_q     <= '0;
      bcd_q     <= '0;
      ovf_q     <= 1'b0;
      valid_q   <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      shift_q   <= shift_d;
      scratch_q <= scratch_d;
      ovf_scr_q <= ovf_scr_d;
      cnt_q     <= cnt_d;
      bcd_q     <= bcd_d;
      ovf_q     <= ovf_d;
      valid_q   <= valid_d;
      ready_q   <= ready_d;
    end
  end

  assign bus.ready    = ready_q;
  assign bus.valid    = valid_q;
  assign bus.bcd      = bcd_q;
  assign bus.overflow = ovf_q;

endmodule
